// File: rtl/ws2812b_decoder.sv
// WS2812B single-wire receiver: classifies high pulses into bits, packs 24-bit pixels onto valid/ready.
// Define WS2812B_DECODER_FWD_EN to forward every word after the first of each frame on dout.
module ws2812b_decoder #(
    parameter int THRESH_CYCLES  = 12,
    parameter int GLITCH_CYCLES  = 3,
    parameter int MAXHIGH_CYCLES = 40,
    parameter int RESET_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] data,
    output logic        valid,
    input  logic        ready,
    output logic        frame_end,
    output logic        frame_err,
    output logic        overrun,
    output logic [8:0]  pixel_count,
    output logic        dout
);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam int HW = $clog2(MAXHIGH_CYCLES + 1);
    localparam logic [LW-1:0] LOW_MAX  = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] LOW_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [HW-1:0] HI_MAX   = HW'(MAXHIGH_CYCLES);
    localparam logic [HW-1:0] HI_THR   = HW'(THRESH_CYCLES);
    localparam logic [HW-1:0] HI_GLT   = HW'(GLITCH_CYCLES);

    typedef enum logic {ST_LOW, ST_HIGH} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, din_s_q, din_s_d, din_p_q, din_p_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [HW-1:0] high_cnt_q, high_cnt_d;
    logic [22:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [23:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_end_q, frame_end_d, frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [8:0]    pix_q, pix_d;
    logic          bit_done, bit_val;
`ifdef WS2812B_DECODER_FWD_EN
    logic          fwd_q, fwd_d;
`endif

    always_comb begin
        state_d     = state_q;
        sync1_d     = din;
        din_s_d     = sync1_q;
        din_p_d     = din_s_q;
        low_cnt_d   = low_cnt_q;
        high_cnt_d  = high_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_end_d = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        pix_d       = pix_q;
        bit_done    = 1'b0;
        bit_val     = 1'b0;
`ifdef WS2812B_DECODER_FWD_EN
        fwd_d       = fwd_q;
`endif
        case (state_q)
            ST_LOW: begin
                if (din_s_q && !din_p_q) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HW'(1);
                end else if (!din_s_q && low_cnt_q < LOW_MAX) begin
                    low_cnt_d = low_cnt_q + LW'(1);
                    // Reset gap reached: close the frame and drop any partial word.
                    if (low_cnt_q == LOW_LAST) begin
                        frame_end_d = 1'b1;
                        frame_err_d = (bit_cnt_q != 5'd0);
                        bit_cnt_d   = 5'd0;
                        shift_d     = '0;
                        pix_d       = '0;
`ifdef WS2812B_DECODER_FWD_EN
                        fwd_d       = 1'b0;
`endif
                    end
                end
            end
            default: begin
                if (din_s_q) begin
                    if (high_cnt_q < HI_MAX) high_cnt_d = high_cnt_q + HW'(1);
                end else begin
                    state_d   = ST_LOW;
                    low_cnt_d = LW'(1);
                    if (high_cnt_q >= HI_MAX) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = 5'd0;
                        shift_d     = '0;
`ifdef WS2812B_DECODER_FWD_EN
                        fwd_d       = 1'b0;
`endif
                    end else if (high_cnt_q >= HI_GLT) begin
                        bit_done = 1'b1;
                        bit_val  = (high_cnt_q >= HI_THR);
                    end
                end
            end
        endcase

        if (valid_q && ready) valid_d = 1'b0;

        if (bit_done) begin
            shift_d = {shift_q[21:0], bit_val};
            if (bit_cnt_q == 5'd23) begin
                bit_cnt_d = 5'd0;
                if (pix_q != 9'd511) pix_d = pix_q + 9'd1;
`ifdef WS2812B_DECODER_FWD_EN
                fwd_d = 1'b1;
`endif
                // A word being consumed this cycle frees the holding register.
                if (!valid_q || ready) begin
                    data_d  = {shift_q, bit_val};
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOW;
            sync1_q     <= 1'b0;
            din_s_q     <= 1'b0;
            din_p_q     <= 1'b0;
            low_cnt_q   <= LOW_MAX;
            high_cnt_q  <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= 5'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_end_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            pix_q       <= '0;
`ifdef WS2812B_DECODER_FWD_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            din_s_q     <= din_s_d;
            din_p_q     <= din_p_d;
            low_cnt_q   <= low_cnt_d;
            high_cnt_q  <= high_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_end_q <= frame_end_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            pix_q       <= pix_d;
`ifdef WS2812B_DECODER_FWD_EN
            fwd_q       <= fwd_d;
`endif
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_end   = frame_end_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign pixel_count = pix_q;
`ifdef WS2812B_DECODER_FWD_EN
    assign dout = fwd_q & din_s_q;
`else
    assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812b_decoder.sv
// Randomized bench for ws2812b_decoder: pulse widths are drawn per bit class, expected words come from the sent bits.
module tb_ws2812b_decoder;
    logic        clk = 1'b0;
    logic        reset, din, ready;
    logic [23:0] data;
    logic        valid, frame_end, frame_err, overrun, dout;
    logic [8:0]  pixel_count;

    always #5 clk = ~clk;

    ws2812b_decoder dut (
        .clk(clk), .reset(reset), .din(din), .data(data), .valid(valid), .ready(ready),
        .frame_end(frame_end), .frame_err(frame_err), .overrun(overrun),
        .pixel_count(pixel_count), .dout(dout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Observation counters, written only by this monitor.
    int          hs_cnt = 0, valid_cyc = 0, fe_cnt = 0, ferr_cnt = 0, coinc_cnt = 0;
    logic [23:0] last_word = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) valid_cyc <= valid_cyc + 1;
            if (valid && ready) begin
                hs_cnt    <= hs_cnt + 1;
                last_word <= data;
            end
            if (frame_end) fe_cnt <= fe_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (frame_end && frame_err) coinc_cnt <= coinc_cnt + 1;
        end
    end

    // Forwarding reference: dout is the line two clocks late while forwarding is expected.
    logic [1:0] din_h = 2'b00;
    logic       fwd_phase = 1'b0, mon_en = 1'b0;
    int         dout_bad = 0;
    always @(negedge clk) begin
        din_h <= {din_h[0], din};
        if (mon_en) begin
`ifdef WS2812B_DECODER_FWD_EN
            if (dout !== (fwd_phase & din_h[1])) dout_bad <= dout_bad + 1;
`else
            if (dout !== 1'b0) dout_bad <= dout_bad + 1;
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        tick(l);
    endtask

    task automatic send_bit(input bit b, input bit fixed);
        if (fixed) pulse(b ? 16 : 8, b ? 9 : 17);
        else pulse(b ? int'($urandom_range(38, 13)) : int'($urandom_range(10, 4)),
                   int'($urandom_range(20, 6)));
    endtask

    // Send n bits of w starting at bit index hi, MSB first.
    task automatic send_bits(input logic [23:0] w, input int hi, input int n, input bit fixed);
        for (int i = 0; i < n; i++) send_bit(w[hi - i], fixed);
    endtask

    logic [23:0] w, w2;
    int s_hs, s_vc, s_fe, s_ferr, s_co, exp_pc;

    initial begin
        reset = 1'b1; din = 1'b0; ready = 1'b0;
        tick(3);
        check_val("rst_data", data, 0);
        check_val("rst_flags", {valid, frame_end, frame_err, overrun, dout}, 0);
        check_val("rst_pixcnt", pixel_count, 0);
        reset = 1'b0;
        tick(2);

        // Reset in the middle of a word and a pulse.
        send_bits(24'h5A5A5A, 23, 5, 1'b0);
        din = 1'b1;
        tick(6);
        #2 reset = 1'b1;
        #2 check_val("midrst_flags", {valid, frame_end, frame_err, overrun, dout}, 0);
        check_val("midrst_data", {pixel_count, data}, 0);
        @(posedge clk); #1;
        reset = 1'b0; din = 1'b0;
        s_fe = fe_cnt; s_ferr = ferr_cnt;
        tick(2000);
        check_val("rst_no_frame_end", fe_cnt - s_fe, 0);
        check_val("rst_no_frame_err", ferr_cnt - s_ferr, 0);

        // Single fixed-timing word.
        ready = 1'b1;
        s_hs = hs_cnt; s_vc = valid_cyc; s_fe = fe_cnt; s_ferr = ferr_cnt;
        send_bits(24'hA5C33C, 23, 24, 1'b1);
        tick(4);
        check_val("single_valid_cycles", valid_cyc - s_vc, 1);
        check_val("single_data", last_word, 24'hA5C33C);
        check_val("single_pixcnt", pixel_count, 1);
        tick(1100);
        check_val("single_frame_end", fe_cnt - s_fe, 1);
        check_val("single_no_err", ferr_cnt - s_ferr, 0);
        check_val("single_pixcnt_clr", pixel_count, 0);

        // Random words with random pulse widths inside each bit class.
        exp_pc = 0;
        for (int k = 0; k < 6; k++) begin
            w = 24'($urandom);
            s_hs = hs_cnt;
            send_bits(w, 23, 24, 1'b0);
            tick(3);
            exp_pc++;
            check_val($sformatf("rand%0d_hs", k), hs_cnt - s_hs, 1);
            check_val($sformatf("rand%0d_data", k), last_word, w);
            check_val($sformatf("rand%0d_pixcnt", k), pixel_count, exp_pc);
        end
        check_val("rand_no_overrun", overrun, 0);
        tick(1100);

        // Overrun: second word arrives while the first is still held.
        ready = 1'b0;
        s_hs = hs_cnt;
        send_bits(24'h123456, 23, 24, 1'b0);
        tick(3);
        check_val("ovr_first_valid", {valid, data}, {1'b1, 24'h123456});
        send_bits(24'hABCDEF, 23, 24, 1'b0);
        tick(3);
        check_val("ovr_data_kept", data, 24'h123456);
        check_val("ovr_flag", overrun, 1);
        check_val("ovr_pixcnt", pixel_count, 2);
        ready = 1'b1;
        tick(2);
        check_val("ovr_valid_drop", valid, 0);
        check_val("ovr_consumed", {hs_cnt - s_hs, 8'h0, last_word}, {32'd1, 8'h0, 24'h123456});
        check_val("ovr_sticky", overrun, 1);
        tick(1100);

        // Partial frame: 10 bits then the reset gap.
        s_vc = valid_cyc; s_fe = fe_cnt; s_ferr = ferr_cnt; s_co = coinc_cnt;
        send_bits(24'($urandom), 23, 10, 1'b0);
        tick(1100);
        check_val("part_frame_err", ferr_cnt - s_ferr, 1);
        check_val("part_frame_end", fe_cnt - s_fe, 1);
        check_val("part_same_cycle", coinc_cnt - s_co, 1);
        check_val("part_no_valid", valid_cyc - s_vc, 0);

        // Glitch between bits is ignored; an over-long pulse discards the partial word.
        w = 24'($urandom);
        s_hs = hs_cnt; s_ferr = ferr_cnt;
        send_bits(w, 23, 12, 1'b0);
        pulse(2, 10);
        send_bits(w, 11, 12, 1'b0);
        tick(3);
        check_val("glitch_hs", hs_cnt - s_hs, 1);
        check_val("glitch_data", last_word, w);
        send_bits(24'($urandom), 23, 5, 1'b0);
        pulse(50, 10);
        tick(1);
        check_val("long_frame_err", ferr_cnt - s_ferr, 1);
        w2 = 24'($urandom);
        send_bits(w2, 23, 24, 1'b0);
        tick(3);
        check_val("after_err_data", last_word, w2);
        tick(1100);
        check_val("after_err_no_more_err", ferr_cnt - s_ferr, 1);
        check_val("after_err_pixcnt", pixel_count, 0);

        // Forwarding over three words, then one bit after frame end.
        s_hs = hs_cnt;
        mon_en = 1'b1;
        send_bits(24'($urandom), 23, 24, 1'b0);
        fwd_phase = 1'b1;
        send_bits(24'($urandom), 23, 24, 1'b0);
        send_bits(24'($urandom), 23, 24, 1'b0);
        tick(1100);
        fwd_phase = 1'b0;
        send_bit(1'b1, 1'b0);
        tick(20);
        mon_en = 1'b0;
        check_val("fwd_dout_bad_cycles", dout_bad, 0);
        check_val("fwd_words", hs_cnt - s_hs, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ws2812b_decoder.md
# ws2812b_decoder

Single-wire WS2812B bitstream decoder: the receive end of the LED-strip link driven by the `ws2812b` transmitter. It samples the strip data line and classifies each high pulse as a 0 or 1 bit. Every 24 bits are assembled into a pixel word and presented on a valid/ready handshake, and the >50 µs low gap is reported as end of frame. It sits on a board input pin, either as a loopback checker for the character-matrix output or as an emulated pixel in a daisy chain, with optional forwarding of downstream bits.

## Interface
Parameters (cycle counts at 20 MHz):
- `THRESH_CYCLES`, 12: a high pulse of at least this many cycles decodes as 1; shorter decodes as 0.
- `GLITCH_CYCLES`, 3: a high pulse shorter than this is ignored entirely.
- `MAXHIGH_CYCLES`, 40: a high pulse of at least this many cycles is a protocol error.
- `RESET_CYCLES`, 1000: a low time of at least this many cycles ends the frame.

Ports:
- `clk`  in  1  system clock, 20 MHz
- `reset`  in  1  asynchronous, active-high reset
- `din`  in  1  strip data line, asynchronous to `clk`
- `data`  out  24  decoded pixel word; the first bit received is `data[23]`
- `valid`  out  1  `data` holds an unconsumed word
- `ready`  in  1  consumer accepts the word
- `frame_end`  out  1  one-cycle pulse when the low gap reaches `RESET_CYCLES`
- `frame_err`  out  1  one-cycle pulse when a partial word is discarded
- `overrun`  out  1  sticky flag: a completed word was dropped
- `pixel_count`  out  9  words completed in the current frame, saturating at 511
- `dout`  out  1  forwarded data line; see Configuration

## Operation
- **Synchronizer:** `din` passes through two flops to give `din_s`. A third flop `din_p` is used for edge detection.
- **Reset values:** all outputs are 0. The state is LOW with the low counter saturated, so no `frame_end` is produced after reset. The shift register, `bit_cnt`, and the forwarding flag are all cleared.
- **State LOW:**
  - Count cycles with `din_s`=0, saturating at `RESET_CYCLES`.
  - When the count reaches `RESET_CYCLES`, assert `frame_end` for one cycle.
  - In that same cycle, if `bit_cnt`≠0, also assert `frame_err` for one cycle.
  - Also in that same cycle, clear `bit_cnt`, the shift register, `pixel_count`, and the forwarding flag.
  - On a rising edge (`din_s`=1, `din_p`=0), go to HIGH with the high count set to 1.
- **State HIGH:**
  - Count cycles with `din_s`=1, saturating at `MAXHIGH_CYCLES`.
  - On a falling edge, go to LOW with the low count set to 1, and classify the pulse by its high count h:
    - h < `GLITCH_CYCLES`: ignore the pulse; no state change other than returning to LOW.
    - h ≥ `MAXHIGH_CYCLES`: pulse `frame_err` and clear `bit_cnt` and the shift register.
    - Otherwise: shift in bit = (h ≥ `THRESH_CYCLES`) at the LSB and increment `bit_cnt`.
- **Word completion:** when `bit_cnt` reaches 24, clear `bit_cnt` and increment `pixel_count` (saturating).
  - If `valid`=0, or `valid`=1 and `ready`=1 in the same cycle, load `data` and set `valid`.
  - Otherwise keep the old word, drop the new one, and set `overrun`.
- **Handshake:** `valid` clears on a cycle where `valid`=1 and `ready`=1, unless a new word loads in that same cycle. `data` is stable while `valid`=1.
- **`overrun`:** cleared only by `reset`.
- **Reset mid-word:** `reset` discards everything immediately and asynchronously; no partial data is emitted.

## Timing
- Let N be the first `clk` edge that samples `din` low after a high pulse.
- `din_s` falls at edge N+1, and decode happens in the cycle that follows.
- The word-completing bit gives `valid`=1 and new `data` at edge N+2.
- Measured high width equals the input high width in cycles for clock-aligned stimulus, and is within ±1 cycle otherwise.
- `frame_end` asserts `RESET_CYCLES` cycles after `din_s` falls.
- There is no combinational path from `ready` to `valid`.

## Configuration
- `WS2812B_DECODER_FWD_EN` defined:
  - The forwarding flag sets on the cycle the first word of a frame completes, and clears on `frame_end`, `frame_err` or `reset`.
  - `dout` = `din_s` while the flag is set, otherwise 0.
  - Switching always occurs while the line is low, so forwarded pulses are never truncated.
  - The first word of each frame is consumed locally; later words appear on `dout` delayed by 2 cycles.
- Not defined: `dout` is tied to 0 and no forwarding logic is built. Decoding behaviour is identical in both builds.

## Test plan
- **Reset:** assert `reset` mid-pulse → all outputs are 0. No `frame_end` occurs during 2000 low cycles after release.
- **Single word:** send 0xA5C33C MSB first (0 = 8 high/17 low cycles, 1 = 16 high/9 low), with `ready`=1 → `valid` for exactly one cycle, `data`=0xA5C33C, `pixel_count`=1. A 1100-cycle low then gives one `frame_end` pulse and `pixel_count`=0.
- **Overrun:** send 0x123456 then 0xABCDEF with `ready`=0 → `data` stays 0x123456 and `overrun`=1. Raise `ready` → `valid` drops and `overrun` remains 1.
- **Partial frame:** send 10 bits then a 1100-cycle low → `frame_err` and `frame_end` pulse in the same cycle, and `valid` never asserts.
- **Glitch and error pulses:** a 2-cycle high inserted between bits is ignored and the word decodes correctly. A 50-cycle high after 5 bits gives a `frame_err` pulse; a following full word decodes correctly.
- **Forwarding (`WS2812B_DECODER_FWD_EN`):** send 3 words → `dout` is 0 during word 1, equals `din` delayed 2 cycles during words 2 and 3, and is 0 after `frame_end`. Without the macro, `dout` is 0 throughout.
